// File: rtl/di_term_fifo.sv
// Host-terminal FIFO bridge: WFIFO (host->device) and RFIFO (device->host), both FWFT,
// behind a STATUS/CTRL/FLAGS register window. Optional loopback via DI_TERM_FIFO_LOOPBACK_EN.
module di_term_fifo #(
    parameter logic [15:0] TERM_ADDR  = 16'h0010,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        ifclk,
    input  logic        reset,
    input  logic [15:0] di_term_addr,
    input  logic [15:0] di_reg_addr,
    input  logic [15:0] di_reg_datai,
    input  logic        di_read_req,
    input  logic        di_read,
    input  logic        di_write,
    output logic [15:0] di_reg_datao,
    output logic        di_read_rdy,
    output logic        di_write_rdy,
    output logic [15:0] wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    input  logic [15:0] rd_data,
    input  logic        rd_valid,
    output logic        rd_ready
);
    localparam int            DEPTH    = 1 << DEPTH_LOG2;
    localparam int            CW       = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [15:0] ADDR_STATUS = 16'h0000;
    localparam logic [15:0] ADDR_CTRL   = 16'h0001;
    localparam logic [15:0] ADDR_FLAGS  = 16'h0002;

    logic [15:0]           wmem_q [DEPTH];
    logic [15:0]           rmem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wf_wp_q, wf_wp_d, wf_rp_q, wf_rp_d;
    logic [DEPTH_LOG2-1:0] rf_wp_q, rf_wp_d, rf_rp_q, rf_rp_d;
    logic [CW-1:0]         wf_cnt_q, wf_cnt_d, rf_cnt_q, rf_cnt_d;
    logic [1:0]            flags_q, flags_d;

    logic        sel, win, host_wr, host_rd, reg_wr_ctrl, reg_wr_flags, flush;
    logic        wf_empty, wf_full, rf_empty, rf_full;
    logic        wf_push, wf_pop, rf_push, rf_pop;
    logic [15:0] wf_head, rf_head, rf_push_data;
    logic        lb, lb_xfer;
    logic [1:0]  flag_set, flag_clr;

    // Prefetch requests need no action: both FIFO heads are always presented.
    logic unused_read_req;
    assign unused_read_req = di_read_req;

    assign sel          = (di_term_addr == TERM_ADDR);
    assign win          = di_reg_addr[15];
    assign host_wr      = sel && di_write;
    assign host_rd      = sel && di_read;
    assign reg_wr_ctrl  = host_wr && !win && (di_reg_addr == ADDR_CTRL);
    assign reg_wr_flags = host_wr && !win && (di_reg_addr == ADDR_FLAGS);
    assign flush        = reg_wr_ctrl && di_reg_datai[0];

    assign wf_empty = (wf_cnt_q == '0);
    assign wf_full  = (wf_cnt_q == FULL_CNT);
    assign rf_empty = (rf_cnt_q == '0);
    assign rf_full  = (rf_cnt_q == FULL_CNT);
    assign wf_head  = wmem_q[wf_rp_q];
    assign rf_head  = rmem_q[rf_rp_q];

`ifdef DI_TERM_FIFO_LOOPBACK_EN
    logic lb_q, lb_d;

    always_comb begin
        lb_d = lb_q;
        if (reg_wr_ctrl) lb_d = di_reg_datai[1];
    end

    always_ff @(posedge ifclk) begin
        if (reset) lb_q <= 1'b0;
        else       lb_q <= lb_d;
    end

    assign lb           = lb_q;
    assign lb_xfer      = lb_q && !wf_empty && !rf_full;
    assign rf_push_data = lb_q ? wf_head : rd_data;
`else
    assign lb           = 1'b0;
    assign lb_xfer      = 1'b0;
    assign rf_push_data = rd_data;
`endif

    assign wr_data  = wf_head;
    assign wr_valid = !reset && !wf_empty && !lb;
    assign rd_ready = reset || (!rf_full && !lb);

    // Fullness/emptiness is judged on the start-of-cycle count, so a same-cycle pop never rescues a push.
    assign wf_push = host_wr && win && !wf_full && !flush;
    assign wf_pop  = (wr_valid && wr_ready) || lb_xfer;
    assign rf_push = lb_xfer || (rd_valid && !rf_full && !lb);
    assign rf_pop  = host_rd && win && !rf_empty;

    always_comb begin
        wf_wp_d  = wf_wp_q;
        wf_rp_d  = wf_rp_q;
        wf_cnt_d = wf_cnt_q;
        if (flush) begin
            wf_wp_d  = '0;
            wf_rp_d  = '0;
            wf_cnt_d = '0;
        end else begin
            if (wf_push) wf_wp_d = wf_wp_q + 1'b1;
            if (wf_pop)  wf_rp_d = wf_rp_q + 1'b1;
            if (wf_push && !wf_pop)      wf_cnt_d = wf_cnt_q + 1'b1;
            else if (!wf_push && wf_pop) wf_cnt_d = wf_cnt_q - 1'b1;
        end
    end

    always_comb begin
        rf_wp_d  = rf_wp_q;
        rf_rp_d  = rf_rp_q;
        rf_cnt_d = rf_cnt_q;
        if (flush) begin
            rf_wp_d  = '0;
            rf_rp_d  = '0;
            rf_cnt_d = '0;
        end else begin
            if (rf_push) rf_wp_d = rf_wp_q + 1'b1;
            if (rf_pop)  rf_rp_d = rf_rp_q + 1'b1;
            if (rf_push && !rf_pop)      rf_cnt_d = rf_cnt_q + 1'b1;
            else if (!rf_push && rf_pop) rf_cnt_d = rf_cnt_q - 1'b1;
        end
    end

    // A set in the same cycle as a write-1-to-clear wins, so no event is lost.
    always_comb begin
        flag_set = 2'b00;
        flag_clr = 2'b00;
        if (host_wr && win && wf_full)  flag_set[0] = 1'b1;
        if (host_rd && win && rf_empty) flag_set[1] = 1'b1;
        if (reg_wr_flags)               flag_clr    = di_reg_datai[1:0];
        flags_d = (flags_q & ~flag_clr) | flag_set;
    end

    always_comb begin
        di_reg_datao = 16'h0000;
        di_write_rdy = 1'b0;
        di_read_rdy  = 1'b0;
        if (sel) begin
            di_write_rdy = win ? !wf_full  : 1'b1;
            di_read_rdy  = win ? !rf_empty : 1'b1;
            if (!reset) begin
                if (win) begin
                    di_reg_datao = rf_empty ? 16'h0000 : rf_head;
                end else begin
                    case (di_reg_addr)
                        ADDR_STATUS: di_reg_datao = {8'(rf_cnt_q), 8'(wf_cnt_q)};
                        ADDR_CTRL:   di_reg_datao = {14'h0000, lb, 1'b0};
                        ADDR_FLAGS:  di_reg_datao = {14'h0000, flags_q};
                        default:     di_reg_datao = 16'h0000;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            wf_wp_q  <= '0;
            wf_rp_q  <= '0;
            wf_cnt_q <= '0;
            rf_wp_q  <= '0;
            rf_rp_q  <= '0;
            rf_cnt_q <= '0;
            flags_q  <= 2'b00;
        end else begin
            wf_wp_q  <= wf_wp_d;
            wf_rp_q  <= wf_rp_d;
            wf_cnt_q <= wf_cnt_d;
            rf_wp_q  <= rf_wp_d;
            rf_rp_q  <= rf_rp_d;
            rf_cnt_q <= rf_cnt_d;
            flags_q  <= flags_d;
        end
    end

    // NOTE: the storage arrays carry no reset; emptiness is tracked by the counts alone.
    always_ff @(posedge ifclk) begin
        if (wf_push) wmem_q[wf_wp_q] <= di_reg_datai;
        if (rf_push) rmem_q[rf_wp_q] <= rf_push_data;
    end
endmodule

// File: doc/di_term_fifo.md
DI_TERM_FIFO -- requirements
Module: di_term_fifo

Interface
REQ-001 SHALL have parameter TERM_ADDR, default 16'h0010, the terminal address this block answers to.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, the log2 of the depth of each FIFO; legal range 2..7.
REQ-003 SHALL have port ifclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have inputs di_term_addr[15:0], di_reg_addr[15:0], di_reg_datai[15:0], di_read_req, di_read and di_write, driven by the host-interface stage.
REQ-006 SHALL have outputs di_reg_datao[15:0], di_read_rdy and di_write_rdy, returned to the host-interface stage.
REQ-007 SHALL have outputs wr_data[15:0] and wr_valid, plus input wr_ready: the host-to-device FIFO head, consumed by device logic.
REQ-008 SHALL have inputs rd_data[15:0] and rd_valid, plus output rd_ready: device-to-host writes into the read FIFO.

Function
REQ-009 The block SHALL be selected only when di_term_addr == TERM_ADDR.
REQ-010 When not selected, di_reg_datao, di_read_rdy and di_write_rdy SHALL be 0, and di_read/di_write SHALL be ignored; this allows OR-combining terminals.
REQ-011 Address map: addresses with di_reg_addr[15]=1 form the FIFO data window; 0x0000 is STATUS (RO); 0x0001 is CTRL (RW); 0x0002 is FLAGS (W1C); all other addresses read 0 and ignore writes.
REQ-012 Two synchronous FIFOs, WFIFO and RFIFO, SHALL each hold 16-bit words with 2^DEPTH_LOG2 entries, DEPTH_LOG2-bit wrapping pointers and a (DEPTH_LOG2+1)-bit count.
REQ-013 Both FIFOs SHALL be first-word-fall-through: wr_data and the RFIFO head are valid combinationally whenever their FIFO is non-empty.
REQ-014 A di_write in the data window with WFIFO not full at the start of the cycle SHALL push di_reg_datai, visible on wr_valid the next cycle.
REQ-015 A di_write in the data window with WFIFO full SHALL drop the data and set FLAGS[0] (overflow); a simultaneous wr_ready pop does not rescue it.
REQ-016 Device pop SHALL occur when wr_valid && wr_ready.
REQ-017 rd_ready SHALL be !RFIFO_full, and device push SHALL occur when rd_valid && rd_ready.
REQ-018 In the data window, di_reg_datao SHALL be the RFIFO head, and di_read SHALL pop it.
REQ-019 A di_read with RFIFO empty SHALL return 0 and set FLAGS[1] (underflow).
REQ-020 A simultaneous push and pop on the same FIFO SHALL leave its count unchanged; pointers SHALL wrap modulo depth.
REQ-021 di_write_rdy SHALL be !WFIFO_full in the data window and 1 at register addresses.
REQ-022 di_read_rdy SHALL be !RFIFO_empty in the data window and 1 at register addresses.
REQ-023 di_read_req SHALL be accepted and ignored, since FWFT needs no prefetch.
REQ-024 STATUS SHALL read {RFIFO_count[7:0], WFIFO_count[7:0]}, zero-extended.
REQ-025 CTRL bit0 (flush) SHALL be self-clearing: writing 1 empties both FIFOs on the following edge.
REQ-026 A flush SHALL take priority over any push or pop in the same cycle; the push is discarded and no flag is set.
REQ-027 Writing 1 to a FLAGS bit SHALL clear it; a set and a clear in the same cycle SHALL leave the bit set.
REQ-028 Register reads SHALL be combinational on di_reg_addr, with zero wait states.
REQ-029 di_reg_addr rolling from 0xFFFF to 0x0000 SHALL leave the data window; no special handling is required.

Reset
REQ-030 On reset, the pointers, counts, FLAGS and CTRL SHALL be 0, and both FIFOs SHALL be empty.
REQ-031 During and after reset: wr_valid=0, rd_ready=1, di_reg_datao=0, and di_read_rdy/di_write_rdy follow REQ-010/021/022.
REQ-032 Reset asserted mid-transfer SHALL discard all FIFO contents within one edge.

Configuration
REQ-033 With DI_TERM_FIFO_LOOPBACK_EN defined, CTRL bit1 (loopback) SHALL exist.
REQ-034 When loopback=1, WFIFO output SHALL feed RFIFO input; rd_ready=0, wr_valid=0, and a word transfers whenever WFIFO is non-empty and RFIFO is not full, one word per cycle.
REQ-035 Without DI_TERM_FIFO_LOOPBACK_EN, CTRL bit1 SHALL read 0, writes to it SHALL be ignored, and no loopback logic SHALL be synthesized.

Verification
REQ-036 Select TERM_ADDR, addr 0x8000, write 0x1111, 0x2222, 0x3333 with wr_ready=0 -> STATUS=0x0003; then wr_ready=1 -> wr_data 0x1111, 0x2222, 0x3333 on consecutive cycles.
REQ-037 Fill WFIFO with 16 words, then issue a 17th di_write -> di_write_rdy=0, word dropped, FLAGS=0x0001; write 0x0001 to FLAGS -> FLAGS=0x0000.
REQ-038 Device pushes 0xABCD, 0x1234; two host di_reads at 0x8000 -> datao 0xABCD then 0x1234; a third read returns 0 and FLAGS[1]=1.
REQ-039 di_term_addr=0x0011 with di_write asserted -> FIFOs unchanged, di_reg_datao=0, both rdy=0.
REQ-040 With RFIFO holding 5 words and a device push in the same cycle as a CTRL flush write -> both counts 0 and FLAGS unchanged.
REQ-041 With the macro defined and CTRL=0x0002, write 0x00AA, 0x00BB -> host reads 0x00AA, 0x00BB back; without the macro, CTRL reads 0x0000.
